// File: rtl/audio_delay_line.sv
// rtl/audio_delay_line.sv - fixed-latency audio sample delay line over an external 16x1024 single-port RAM
// Optional zero-fill of never-written slots is enabled by defining AUDIO_DELAY_ZERO_FILL_EN.
module audio_delay_line #(
   parameter int RAM_RD_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sample_in,
   input  logic        sample_in_valid,
   output logic        sample_in_ready,
   input  logic [9:0]  delay,
   output logic [15:0] sample_out,
   output logic        sample_out_valid,
   output logic [9:0]  ram_addr,
   output logic [15:0] ram_wr_data,
   output logic        ram_wr_en,
   input  logic [15:0] ram_rd_data
);

   typedef enum logic [1:0] {IDLE, RD, WAIT, CAP_WR} state_t;

   localparam int         WAIT_CYCLES = (RAM_RD_LATENCY > 1) ? RAM_RD_LATENCY - 1 : 1;
   localparam logic [7:0] WAIT_LAST   = 8'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [9:0]  wptr;
   logic [15:0] sample_q;
   logic [9:0]  dly_q;
   logic [7:0]  wait_cnt;
   logic [9:0]  rd_addr;
   logic [15:0] cap_data;
   logic        accept;

   assign accept  = sample_in_valid & sample_in_ready;
   // a stored delay of 0 means 1024, which is wptr itself modulo 1024
   assign rd_addr = wptr - dly_q;

`ifdef AUDIO_DELAY_ZERO_FILL_EN
   logic [10:0] fill_cnt;
   logic [10:0] dly_full;

   assign dly_full = {(dly_q == 10'd0), dly_q};
   assign cap_data = (fill_cnt < dly_full) ? 16'd0 : ram_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_cnt <= 11'd0;
      end else if (state == CAP_WR && fill_cnt != 11'd1024) begin
         fill_cnt <= fill_cnt + 11'd1;
      end
   end
`else
   assign cap_data = ram_rd_data;
`endif

   always_comb begin
      state_nxt       = state;
      sample_in_ready = 1'b0;
      ram_addr        = 10'd0;
      ram_wr_data     = 16'd0;
      ram_wr_en       = 1'b0;
      case (state)
         IDLE: begin
            sample_in_ready = 1'b1;
            if (sample_in_valid) state_nxt = RD;
         end
         RD: begin
            ram_addr  = rd_addr;
            state_nxt = (RAM_RD_LATENCY > 1) ? WAIT : CAP_WR;
         end
         WAIT: begin
            ram_addr = rd_addr;
            if (wait_cnt == WAIT_LAST) state_nxt = CAP_WR;
         end
         CAP_WR: begin
            ram_addr    = wptr;
            ram_wr_data = sample_q;
            ram_wr_en   = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         wptr             <= 10'd0;
         sample_q         <= 16'd0;
         dly_q            <= 10'd0;
         wait_cnt         <= 8'd0;
         sample_out       <= 16'd0;
         sample_out_valid <= 1'b0;
      end else begin
         state            <= state_nxt;
         sample_out_valid <= (state == CAP_WR);
         if (accept) begin
            sample_q <= sample_in;
            dly_q    <= delay;
         end
         if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
         else               wait_cnt <= 8'd0;
         if (state == CAP_WR) begin
            wptr       <= wptr + 10'd1;
            sample_out <= cap_data;
         end
      end
   end

endmodule

// File: doc/audio_delay_line.md
AUDIO_DELAY_LINE -- requirements
Module: audio_delay_line

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk               input   1   system clock, all logic on rising edge
  rst               input   1   synchronous active-high reset
  sample_in         input   16  audio sample to store
  sample_in_valid   input   1   sample_in present
  sample_in_ready   output  1   block can accept a sample
  delay             input   10  delay in samples; 0 = 1024
  sample_out        output  16  delayed sample
  sample_out_valid  output  1   one-cycle strobe, sample_out valid
  ram_addr          output  10  to 16x1024 single-port RAM addr
  ram_wr_data       output  16  to RAM wr_data
  ram_wr_en         output  1   to RAM wr_en
  ram_rd_data       input   16  from RAM rd_data (2-cycle read latency, output register on)
REQ-003 The block SHALL have one parameter: RAM_RD_LATENCY, default 2, RAM clocks from read address to ram_rd_data valid.

Function
REQ-004 The FSM SHALL have states IDLE, RD, WAIT, CAP_WR; WAIT lasts RAM_RD_LATENCY-1 cycles.
REQ-005 In IDLE only, sample_in_ready SHALL be 1; a transfer occurs when valid and ready are both 1; sample_in and delay are latched and the FSM goes to RD.
REQ-006 In RD, ram_addr SHALL be wptr - D mod 1024 (D = latched delay, 0 treated as 1024), and ram_wr_en SHALL be 0.
REQ-007 WAIT SHALL hold ram_wr_en at 0 and ram_addr at the RD value.
REQ-008 In CAP_WR, the block SHALL register ram_rd_data for output, drive ram_addr=wptr, ram_wr_data=latched sample, and ram_wr_en=1.
REQ-009 On leaving CAP_WR, wptr SHALL increment mod 1024 (1023 wraps to 0), and the FSM SHALL return to IDLE.
REQ-010 sample_out_valid SHALL pulse for exactly the cycle after CAP_WR; sample_out SHALL hold its value until the next pulse.
REQ-011 Latency SHALL be fixed: transfer accepted at edge N gives sample_out_valid=1 in cycle N+4 (default latency), with ready back to 1 in that same cycle.
REQ-012 Throughput SHALL be at most one sample per 4 cycles; sample_in_valid while not ready SHALL be ignored, with no loss of the held request.
REQ-013 The k-th accepted sample (k from 0) SHALL produce out = in[k-D] when k >= D.
REQ-014 Changes to delay while busy SHALL NOT affect the in-flight sample.
REQ-015 ram_wr_en SHALL be 1 only in CAP_WR; reads and writes SHALL never overlap.

Reset
REQ-016 On rst=1 at a clock edge, from any state including mid-operation, the block SHALL force:
  - FSM to IDLE, wptr=0, fill count=0
  - sample_out=0, sample_out_valid=0
  - ram_wr_en=0, ram_addr=0, ram_wr_data=0
REQ-017 An in-flight sample SHALL be discarded by reset; RAM contents are not cleared.
REQ-018 sample_in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-019 Macro AUDIO_DELAY_ZERO_FILL_EN SHALL control zero-filling of unwritten slots.
REQ-020 With AUDIO_DELAY_ZERO_FILL_EN defined:
  - an 11-bit fill counter SHALL count written samples, saturating at 1024
  - sample_out SHALL be 0 while fill count < D, at the time of capture
REQ-021 Without AUDIO_DELAY_ZERO_FILL_EN, the counter SHALL be absent and sample_out SHALL always be raw ram_rd_data.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, then delay=3, feed 1,2,3,4,5 -> outputs 0,0,0,1,2 (ZERO_FILL_EN); each valid 4 cycles after its accept.
  - Hold sample_in_valid=1 continuously -> ready pattern 1,0,0,0 repeating; ram_wr_en high only in CAP_WR; no dropped samples.
  - delay=0, feed 1100 ramp samples 0..1099 -> sample 1024 outputs 0, sample 1099 outputs 75; wptr wraps 1023->0.
  - delay=1, change delay to 500 during RD -> that sample still uses D=1; the next uses D=500.
  - Assert rst during WAIT -> no sample_out_valid; ram_wr_en stays 0; next sample writes at addr 0.
  - Without AUDIO_DELAY_ZERO_FILL_EN, preload RAM addr 1021 = 0xABCD, delay=3, first sample -> sample_out=0xABCD.
